// File: rtl/opnd_fetch_if.sv
// opnd_fetch_if: decoded-instruction input, ALU-side output and writeback port
// of the operand-fetch stage; slave is the stage, master is its environment.
interface opnd_fetch_if #(
    parameter int NBITS = 16,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic [AW-1:0]    in_rd;
    logic             in_wr;
    logic             in_use_imm;
    logic [NBITS-1:0] in_imm;

    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_op;
    logic [NBITS-1:0] out_opnd1;
    logic [NBITS-1:0] out_opnd2;
    logic [AW-1:0]    out_rd;
    logic             out_wr;

    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [NBITS-1:0] wb_data;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd,
        output in_wr, in_use_imm, in_imm,
        input  in_ready,
        input  out_valid, out_op, out_opnd1, out_opnd2,
        input  out_rd, out_wr,
        output out_ready,
        output wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd,
        input  in_wr, in_use_imm, in_imm,
        output in_ready,
        output out_valid, out_op, out_opnd1, out_opnd2,
        output out_rd, out_wr,
        input  out_ready,
        input  wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/opnd_fetch.sv
// opnd_fetch: register bank, pending-write scoreboard and registered ALU operands.
// Define OPND_FETCH_BYPASS_EN to forward writeback data to same-cycle readers.
module opnd_fetch #(
    parameter int NBITS = 16,
    parameter int NREGS = 16
) (
    input logic         clk,
    input logic         rst_n,
    opnd_fetch_if.slave bus
);
    logic [NBITS-1:0] rf [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic             pend1;
    logic             pend2;
    logic             pendd;
    logic             hazard;
    logic             accept;
    logic [NBITS-1:0] rd1;
    logic [NBITS-1:0] rd2;

`ifdef OPND_FETCH_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1  = bus.wb_en && (bus.wb_addr == bus.in_rs1);
    assign hit2  = bus.wb_en && (bus.wb_addr == bus.in_rs2);
    assign pend1 = pending[bus.in_rs1] && !hit1;
    assign pend2 = pending[bus.in_rs2] && !hit2;
    assign rd1   = hit1 ? bus.wb_data : rf[bus.in_rs1];
    assign rd2   = hit2 ? bus.wb_data : rf[bus.in_rs2];
`else
    assign pend1 = pending[bus.in_rs1];
    assign pend2 = pending[bus.in_rs2];
    assign rd1   = rf[bus.in_rs1];
    assign rd2   = rf[bus.in_rs2];
`endif

    // WAW waits for the clear edge even when forwarding is enabled
    assign pendd  = bus.in_wr && pending[bus.in_rd];
    assign hazard = pend1 || (!bus.in_use_imm && pend2) || pendd;

    assign bus.in_ready = !hazard && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // set after clear so a same-index collision leaves the bit set
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_en)
            pending_nxt[bus.wb_addr] = 1'b0;
        if (accept && bus.in_wr)
            pending_nxt[bus.in_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
            pending <= '0;
        end else begin
            if (bus.wb_en)
                rf[bus.wb_addr] <= bus.wb_data;
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_op    <= '0;
            bus.out_opnd1 <= '0;
            bus.out_opnd2 <= '0;
            bus.out_rd    <= '0;
            bus.out_wr    <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_op    <= bus.in_op;
            bus.out_opnd1 <= rd1;
            bus.out_opnd2 <= bus.in_use_imm ? bus.in_imm : rd2;
            bus.out_rd    <= bus.in_rd;
            bus.out_wr    <= bus.in_wr;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_opnd_fetch.sv
// tb_opnd_fetch: directed checks of operand fetch, scoreboard stalls,
// backpressure and asynchronous reset.
module tb_opnd_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   waited;

  opnd_fetch_if #(.NBITS(16), .NREGS(16)) bus ();

  opnd_fetch #(.NBITS(16), .NREGS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [3:0]  op,
    input logic [3:0]  rs1,
    input logic [3:0]  rs2,
    input logic [3:0]  rd,
    input logic        wr,
    input logic        use_imm,
    input logic [15:0] imm
  );
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rd      = rd;
    bus.in_wr      = wr;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd      = '0;
    bus.in_wr      = 1'b0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.out_ready  = 1'b1;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;

    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_opnd1", bus.out_opnd1, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;

    issue(4'd0, 4'd3, 4'd5, 4'd0,
          1'b0, 1'b0, 16'h0);
    #1;
    chk("first_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("first_out_valid", bus.out_valid, 1'b1);
    chk("first_opnd1", bus.out_opnd1, 16'h0000);
    chk("first_opnd2", bus.out_opnd2, 16'h0000);

    bus.wb_en   = 1'b1;
    bus.wb_addr = 4'd2;
    bus.wb_data = 16'h1234;
    tick();
    bus.wb_en = 1'b0;
    chk("drain_out_valid", bus.out_valid, 1'b0);
    issue(4'd2, 4'd2, 4'd0, 4'd0,
          1'b0, 1'b1, 16'h0005);
    tick();
    bus.in_valid = 1'b0;
    chk("imm_opnd1", bus.out_opnd1, 16'h1234);
    chk("imm_opnd2", bus.out_opnd2, 16'h0005);
    chk("imm_op", bus.out_op, 4'd2);

    issue(4'd1, 4'd0, 4'd0, 4'd4,
          1'b1, 1'b0, 16'h0);
    tick();
    chk("raw_wr_out_wr", bus.out_wr, 1'b1);
    issue(4'd1, 4'd4, 4'd0, 4'd0,
          1'b0, 1'b0, 16'h0);
    #1;
    chk("raw_stall0", bus.in_ready, 1'b0);
    tick();
    chk("raw_stall1", bus.in_ready, 1'b0);
    tick();
    chk("raw_stall2", bus.in_ready, 1'b0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 4'd4;
    bus.wb_data = 16'hBEEF;
    #1;
`ifdef OPND_FETCH_BYPASS_EN
    chk("raw_wb_cycle_ready", bus.in_ready, 1'b1);
    tick();
    bus.wb_en    = 1'b0;
    bus.in_valid = 1'b0;
`else
    chk("raw_wb_cycle_ready", bus.in_ready, 1'b0);
    tick();
    bus.wb_en = 1'b0;
    #1;
    waited = 0;
    while (!bus.in_ready && waited < 4) begin
      #1;
      waited++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $error("FAIL raw_wait expired after %0d",
             waited);
    end
    chk("raw_after_wb_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
`endif
    chk("raw_out_valid", bus.out_valid, 1'b1);
    chk("raw_opnd1", bus.out_opnd1, 16'hBEEF);
    tick();

    bus.out_ready = 1'b0;
    issue(4'd3, 4'd2, 4'd4, 4'd1,
          1'b0, 1'b0, 16'h0);
    tick();
    chk("bp_a_loaded", bus.out_op, 4'd3);
    issue(4'd5, 4'd4, 4'd0, 4'd0,
          1'b0, 1'b1, 16'h0077);
    #1;
    chk("bp_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_op", bus.out_op, 4'd3);
      chk("bp_hold_opnd1", bus.out_opnd1,
          16'h1234);
      chk("bp_hold_opnd2", bus.out_opnd2,
          16'hBEEF);
      chk("bp_hold_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_b_op", bus.out_op, 4'd5);
    chk("bp_b_opnd1", bus.out_opnd1, 16'hBEEF);
    chk("bp_b_opnd2", bus.out_opnd2, 16'h0077);
    tick();

    issue(4'd6, 4'd0, 4'd0, 4'd7,
          1'b1, 1'b0, 16'h0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 4'd7;
    bus.wb_data = 16'h5555;
    tick();
    bus.wb_en = 1'b0;
    issue(4'd0, 4'd7, 4'd0, 4'd0,
          1'b0, 1'b0, 16'h0);
    #1;
    chk("sim_stall0", bus.in_ready, 1'b0);
    tick();
    chk("sim_stall1", bus.in_ready, 1'b0);
    chk("sim_no_accept", bus.out_valid, 1'b0);
    bus.in_valid = 1'b0;

    bus.out_ready = 1'b0;
    issue(4'd9, 4'd2, 4'd0, 4'd4,
          1'b1, 1'b0, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_out_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_op", bus.out_op, 4'd0);
    chk("arst_opnd1", bus.out_opnd1, 16'h0000);
    chk("arst_out_wr", bus.out_wr, 1'b0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    issue(4'd0, 4'd4, 4'd0, 4'd0,
          1'b0, 1'b0, 16'h0);
    #1;
    chk("post_rst_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_out_valid", bus.out_valid, 1'b1);
    chk("post_rst_opnd1", bus.out_opnd1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
